// File: rtl/riscv_regfile.sv
// Integer register file: 32 x XLEN, one write port, two combinational read ports.
// Reset launches a one-entry-per-cycle clear of x1..x31 before the file is usable.
module riscv_regfile #(
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                i_regfile_clk,
    input  logic                i_regfile_rst,
    input  logic                i_regfile_rd_we,
    input  logic [REG_ADDR-1:0] i_regfile_rd_addr,
    input  logic [XLEN-1:0]     i_regfile_rd_data,
    input  logic [REG_ADDR-1:0] i_regfile_rs1_addr,
    output logic [XLEN-1:0]     o_regfile_rs1_data,
    input  logic [REG_ADDR-1:0] i_regfile_rs2_addr,
    output logic [XLEN-1:0]     o_regfile_rs2_data,
    output logic                o_regfile_ready
);

    // Handshake: o_regfile_ready=1 means read data is valid and writes are
    // accepted; while 0, reads return 0 and writes are dropped. No backpressure.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [REG_ADDR-1:0] LAST_ADDR = REG_ADDR'(REG_NUM - 1);

    state_t              state;
    logic [REG_ADDR-1:0] cnt;
    logic [XLEN-1:0]     mem [REG_NUM];

    always_ff @(posedge i_regfile_clk) begin
        if (i_regfile_rst) begin
            state           <= ST_CLEAR;
            cnt             <= REG_ADDR'(1);
            o_regfile_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + REG_ADDR'(1);
                    if (cnt == LAST_ADDR) begin
                        state           <= ST_READY;
                        o_regfile_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    state           <= ST_READY;
                    o_regfile_ready <= 1'b1;
                end
                default: begin
                    state           <= ST_CLEAR;
                    cnt             <= REG_ADDR'(1);
                    o_regfile_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the clear sequence defines its contents.
    always_ff @(posedge i_regfile_clk) begin
        if (!i_regfile_rst) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= '0;
            end else if (i_regfile_rd_we && (i_regfile_rd_addr != '0)) begin
                mem[i_regfile_rd_addr] <= i_regfile_rd_data;
            end
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (!o_regfile_ready || (addr == '0)) begin
            val = '0;
        end else if (i_regfile_rd_we && (i_regfile_rd_addr == addr)) begin
            val = i_regfile_rd_data;
        end else begin
            val = mem[addr];
        end
        return val;
    endfunction

    always_comb begin
        o_regfile_rs1_data = read_port(i_regfile_rs1_addr);
        o_regfile_rs2_data = read_port(i_regfile_rs2_addr);
    end

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed bench for riscv_regfile: clear latency, readback, bypass, x0,
// writes during clear and reset during clear / while ready.
module tb_riscv_regfile;

  localparam int XLEN     = 32;
  localparam int REG_NUM  = 32;
  localparam int REG_ADDR = 5;

  logic                clk;
  logic                rst;
  logic                rd_we;
  logic [REG_ADDR-1:0] rd_addr;
  logic [XLEN-1:0]     rd_data;
  logic [REG_ADDR-1:0] rs1_addr;
  logic [XLEN-1:0]     rs1_data;
  logic [REG_ADDR-1:0] rs2_addr;
  logic [XLEN-1:0]     rs2_data;
  logic                ready;

  int n_cmp;
  int n_fail;
  logic [XLEN-1:0] exp_q[$];

  riscv_regfile #(
    .XLEN     (XLEN),
    .REG_NUM  (REG_NUM),
    .REG_ADDR (REG_ADDR)
  ) dut (
    .i_regfile_clk      (clk),
    .i_regfile_rst      (rst),
    .i_regfile_rd_we    (rd_we),
    .i_regfile_rd_addr  (rd_addr),
    .i_regfile_rd_data  (rd_data),
    .i_regfile_rs1_addr (rs1_addr),
    .o_regfile_rs1_data (rs1_data),
    .i_regfile_rs2_addr (rs2_addr),
    .o_regfile_rs2_data (rs2_data),
    .o_regfile_ready    (ready)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic we, input logic [REG_ADDR-1:0] a, input logic [XLEN-1:0] d);
    rd_we   = we;
    rd_addr = a;
    rd_data = d;
  endtask

  task automatic drive_reads(input logic [REG_ADDR-1:0] a1, input logic [REG_ADDR-1:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard pop: compare an observed value with the oldest expected one
  task automatic check_q(input string tag, input logic [XLEN-1:0] obs);
    logic [XLEN-1:0] exp;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      check(tag, obs, exp);
    end
  endtask

  // after the last reset edge: ready must stay 0 for 30 edges, rise on the 31st
  task automatic wait_clear(input string tag);
    for (int i = 1; i <= REG_NUM - 1; i++) begin
      tick();
      check(tag, {31'd0, ready}, (i == REG_NUM - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive_write(1'b0, '0, '0);
    drive_reads(5'd1, 5'd2);

    // reset held for 3 edges
    tick();
    tick();
    tick();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rs1", rs1_data, 32'd0);
    check("reset_rs2", rs2_data, 32'd0);
    rst = 1'b0;

    // write attempted during clear, read of x3 forced to 0 while not ready
    drive_write(1'b1, 5'd3, 32'h0000_0055);
    drive_reads(5'd3, 5'd3);
    check("clear_rs1_forced0", rs1_data, 32'd0);
    tick();
    check("clear_ready_e1", {31'd0, ready}, 32'd0);
    tick();
    drive_write(1'b0, '0, '0);
    for (int i = 3; i <= REG_NUM - 1; i++) begin
      tick();
      check("clear_ready", {31'd0, ready}, (i == REG_NUM - 1) ? 32'd1 : 32'd0);
    end

    // every register reads 0 on both ports after the clear
    for (int a = 1; a < REG_NUM; a++) begin
      drive_reads(REG_ADDR'(a), REG_ADDR'(a));
      check("cleared_rs1", rs1_data, 32'd0);
      check("cleared_rs2", rs2_data, 32'd0);
    end

    // write and read back
    drive_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive_write(1'b1, 5'd31, 32'h1234_5678);
    tick();
    drive_write(1'b0, '0, '0);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h1234_5678);
    drive_reads(5'd5, 5'd31);
    check_q("readback_x5", rs1_data);
    check_q("readback_x31", rs2_data);

    // bypass: both ports see the write in the same cycle, then from storage
    drive_write(1'b1, 5'd7, 32'hA5A5_A5A5);
    drive_reads(5'd7, 5'd7);
    check("bypass_rs1", rs1_data, 32'hA5A5_A5A5);
    check("bypass_rs2", rs2_data, 32'hA5A5_A5A5);
    tick();
    drive_write(1'b0, '0, '0);
    drive_reads(5'd7, 5'd5);
    check("stored_x7", rs1_data, 32'hA5A5_A5A5);
    check("stored_x5", rs2_data, 32'hDEAD_BEEF);

    // bypass over an existing value on one port only
    drive_write(1'b1, 5'd5, 32'h0BAD_F00D);
    drive_reads(5'd5, 5'd7);
    check("bypass_over_x5", rs1_data, 32'h0BAD_F00D);
    check("no_bypass_x7", rs2_data, 32'hA5A5_A5A5);
    tick();

    // x0 write discarded
    drive_write(1'b1, 5'd0, 32'hFFFF_FFFF);
    drive_reads(5'd0, 5'd0);
    check("x0_same_cycle_rs1", rs1_data, 32'd0);
    check("x0_same_cycle_rs2", rs2_data, 32'd0);
    tick();
    drive_write(1'b0, '0, '0);
    drive_reads(5'd0, 5'd0);
    check("x0_later", rs1_data, 32'd0);
    tick();
    check("x0_later2", rs2_data, 32'd0);

    // back-to-back writes to the same register: last one wins
    drive_write(1'b1, 5'd12, 32'h0000_0001);
    tick();
    drive_write(1'b1, 5'd12, 32'h0000_0002);
    tick();
    drive_write(1'b0, '0, '0);
    drive_reads(5'd12, 5'd12);
    check("b2b_x12", rs1_data, 32'h0000_0002);

    // reset while ready: x10 written, then a 1-edge reset pulse
    drive_write(1'b1, 5'd10, 32'h0000_0099);
    tick();
    drive_write(1'b0, '0, '0);
    drive_reads(5'd10, 5'd31);
    check("x10_before_rst", rs1_data, 32'h0000_0099);
    rst = 1'b1;
    drive_write(1'b1, 5'd10, 32'h0000_0077);
    tick();
    rst = 1'b0;
    drive_write(1'b0, '0, '0);
    drive_reads(5'd10, 5'd31);
    check("rst_ready_drop", {31'd0, ready}, 32'd0);
    check("rst_rs1_forced0", rs1_data, 32'd0);
    wait_clear("reclear_ready");
    drive_reads(5'd10, 5'd31);
    check("x10_after_reclear", rs1_data, 32'd0);
    check("x31_after_reclear", rs2_data, 32'd0);

    // reset pulse 10 edges into a clear restarts the full latency
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("midclear_ready", {31'd0, ready}, 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("restart_ready");
    drive_reads(5'd5, 5'd12);
    check("x5_after_restart", rs1_data, 32'd0);
    check("x12_after_restart", rs2_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_regfile.md
# riscv_regfile

Integer register file for the RISC-V core: 32 × XLEN storage with one write port fed by writeback and two combinational read ports consumed by decode. A synchronous active-high reset launches a sequential clear that zeroes x1..x31 one entry per cycle. `o_regfile_ready` gates the pipeline until the clear completes. x0 is hardwired to zero, and a same-cycle write is forwarded to the read ports.

## Interface
- XLEN, 32, data width of every register and port
- REG_NUM, 32, number of architectural registers; must be a power of two
- REG_ADDR, 5, address width; equals log2(REG_NUM)

- i_regfile_clk  in  1  clock; all state updates on its rising edge
- i_regfile_rst  in  1  reset; synchronous and active-high, sampled on the rising clock edge
- i_regfile_rd_we  in  1  write enable from writeback
- i_regfile_rd_addr  in  REG_ADDR  write address
- i_regfile_rd_data  in  XLEN  write data
- i_regfile_rs1_addr  in  REG_ADDR  read port 1 address
- o_regfile_rs1_data  out  XLEN  read port 1 data; combinational
- i_regfile_rs2_addr  in  REG_ADDR  read port 2 address
- o_regfile_rs2_data  out  XLEN  read port 2 data; combinational
- o_regfile_ready  out  1  registered; 1 = clear finished, reads and writes are valid

## Operation
- State machine with two states, CLEAR and READY, plus a REG_ADDR-bit clear counter `cnt`.
- Reset:
  - On any edge where rst=1: state←CLEAR, cnt←1, o_regfile_ready←0.
  - Storage is not touched on a reset edge itself.
  - Reset wins over every other input on that edge.
- CLEAR, on each edge with rst=0:
  - mem[cnt]←0 and cnt←cnt+1.
  - If cnt==REG_NUM-1: state←READY and o_regfile_ready←1 on that same edge.
  - cnt wraps to 0 in this case; the wrapped value is unused.
  - Writes are ignored for the whole of CLEAR.
- READY, on each edge with rst=0:
  - If rd_we=1 and rd_addr≠0: mem[rd_addr]←rd_data.
  - Writes to x0 are discarded.
  - The state stays READY until the next reset.
- Read path, evaluated independently per port (rsN):
  - If o_regfile_ready=0: the output is 0, whatever the address.
  - Else if rsN_addr==0: the output is 0.
  - Else if rd_we=1 and rd_addr==rsN_addr: the output is i_regfile_rd_data (write-through bypass).
  - Otherwise the output is mem[rsN_addr].
- Both ports may read the same address; each applies the bypass independently.
- mem has no reset of its own. Contents are defined only after a completed CLEAR.
- x0 is never stored and is never read from storage.

## Timing
- Reset values: o_regfile_ready=0; o_regfile_rs1_data and o_regfile_rs2_data=0 (forced by ready=0).
- Clear latency: o_regfile_ready rises on the 31st edge (REG_NUM-1) after the last edge at which rst was sampled high.
- Reset mid-clear: cnt restarts at 1 and the full clear latency applies again.
- Reset while READY: ready drops on that edge, and register contents are zeroed again by the new clear.
- Write latency: data presented at edge E is stored at E.
  - Via the bypass it is visible on the read ports during the cycle before E.
  - From storage it is visible from E onward.
- Read latency: 0 cycles, combinational from address and storage.
- Back-to-back writes to the same register in consecutive cycles are legal; the last one wins.
- No backpressure. The only pipeline stall source is o_regfile_ready=0.

## Test plan
- Reset and clear:
  - Stimulus: hold rst=1 for 3 edges, then release.
  - Required: ready=0 for the next 30 edges and rises on the 31st.
  - Required after ready: reads of x1..x31 on both ports all return 0.
- Write and read back:
  - Stimulus: after ready, write x5=0xDEADBEEF and x31=0x12345678 on consecutive cycles.
  - Required: the next cycle, rs1=5 returns 0xDEADBEEF and rs2=31 returns 0x12345678.
- Bypass and x0:
  - Stimulus A: rd_we=1, rd=7, data=0xA5A5A5A5 with rs1=rs2=7.
  - Required A: both ports show 0xA5A5A5A5 in the same cycle.
  - Stimulus B: write x0=0xFFFFFFFF with rs1=0.
  - Required B: 0 in the same cycle and every later cycle.
- Write during CLEAR:
  - Stimulus: while ready=0, assert rd_we=1, rd=3, data=0x55.
  - Required: after ready, x3 reads 0.
- Reset mid-operation:
  - Stimulus A: write x10=0x99 and reach ready, then pulse rst for 1 edge.
  - Required A: ready drops on that edge and returns 31 edges later; x10 then reads 0.
  - Stimulus B: pulse rst again 10 edges into a clear.
  - Required B: ready rises 31 edges after the second pulse, not earlier.
